fetch_sequencer: RTL and testbench

- Multi-cycle control sequencer for the non-pipelined MIPS core.
- Generates the one-hot `state` bus that gates the PC, instruction memory, register file, ALU and data memory.
- Decides per-instruction phase sequence, PC update timing and PC source; holds in MEM while data memory is busy.
- Provides instruction/cycle counters and a halt/error status.

---
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Control/status bundle between the multi-cycle sequencer and the rest of the
// MIPS core: decode/flag inputs in, one-hot phase, strobes and counters out.
interface fetch_sequencer_if #(
  parameter int COUNT_W = 32
);
  logic               start;
  logic [5:0]         opcode;
  logic               alu_zero;
  logic               mem_ready;
  logic [5:0]         state;
  logic               PC_enable;
  logic [1:0]         pc_sel;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;
  logic               error;
  logic [COUNT_W-1:0] instr_count;
  logic [COUNT_W-1:0] cycle_count;

  modport master (
    input  start, opcode, alu_zero, mem_ready,
    output state, PC_enable, pc_sel, reg_write, mem_read, mem_write,
           error, instr_count, cycle_count
  );

  modport slave (
    output start, opcode, alu_zero, mem_ready,
    input  state, PC_enable, pc_sel, reg_write, mem_read, mem_write,
           error, instr_count, cycle_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle phase sequencer for the non-pipelined MIPS core: one-hot phase
// bus, PC update strobe/source, memory/regfile strobes, counters, error halt.
module fetch_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000000,
    S_FETCH  = 6'b000001,
    S_DECODE = 6'b000010,
    S_EXEC   = 6'b000100,
    S_MEM    = 6'b001000,
    S_WB     = 6'b010000,
    S_HALT   = 6'b100000
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_opcode;
  logic [7:0]         r_tmo;
  logic               r_error;
  logic [COUNT_W-1:0] r_instr_count;
  logic [COUNT_W-1:0] r_cycle_count;

  logic       w_pc_enable;
  logic [1:0] w_pc_sel;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_timeout;
  logic       w_is_alu;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_beq;
  logic       w_is_j;
  logic       w_active;

  assign w_is_alu = (r_opcode == OP_RTYPE) || (r_opcode == OP_ADDI);
  assign w_is_lw  = (r_opcode == OP_LW);
  assign w_is_sw  = (r_opcode == OP_SW);
  assign w_is_beq = (r_opcode == OP_BEQ);
  assign w_is_j   = (r_opcode == OP_J);
  assign w_active = (r_state != S_IDLE) && (r_state != S_HALT);

  always_comb begin
    w_next      = r_state;
    w_pc_enable = 1'b0;
    w_pc_sel    = 2'b00;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      // DECODE steers on the live opcode; later phases use the latched copy
      S_DECODE: w_next = (bus.opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_is_alu) begin
          w_next = S_WB;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else begin
          // beq, j and NOP retire here
          w_next      = S_FETCH;
          w_pc_enable = 1'b1;
          if (w_is_j)                        w_pc_sel = 2'b10;
          else if (w_is_beq && bus.alu_zero) w_pc_sel = 2'b01;
        end
      end
      S_MEM: begin
        w_mem_read  = w_is_lw;
        w_mem_write = w_is_sw;
        if (bus.mem_ready) begin
          if (w_is_lw) begin
            w_next = S_WB;
          end else begin
            w_next      = S_FETCH;
            w_pc_enable = 1'b1;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_next    = S_HALT;
          w_timeout = 1'b1;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_pc_enable = 1'b1;
        w_next      = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_opcode      <= 6'b000000;
      r_tmo         <= 8'd0;
      r_error       <= 1'b0;
      r_instr_count <= '0;
      r_cycle_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.opcode;
      // wait counter only survives consecutive not-ready MEM cycles
      if ((r_state == S_MEM) && !bus.mem_ready && !w_timeout) r_tmo <= r_tmo + 8'd1;
      else                                                    r_tmo <= 8'd0;
      if (w_timeout)   r_error       <= 1'b1;
      if (w_pc_enable) r_instr_count <= r_instr_count + COUNT_W'(1);
      if (w_active)    r_cycle_count <= r_cycle_count + COUNT_W'(1);
    end
  end

  assign bus.state       = r_state;
  assign bus.PC_enable   = w_pc_enable;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.reg_write   = w_reg_write;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.error       = r_error;
  assign bus.instr_count = r_instr_count;
  assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: random instruction streams expanded into expected
// per-cycle phase records by an instruction-level model, compared every cycle.
module tb_fetch_sequencer;
  localparam int MEM_TIMEOUT = 4;
  localparam int COUNT_W     = 32;

  localparam logic [5:0] ST_IDLE = 6'b000000;
  localparam logic [5:0] ST_F    = 6'b000001;
  localparam logic [5:0] ST_D    = 6'b000010;
  localparam logic [5:0] ST_E    = 6'b000100;
  localparam logic [5:0] ST_M    = 6'b001000;
  localparam logic [5:0] ST_WB   = 6'b010000;
  localparam logic [5:0] ST_H    = 6'b100000;

  typedef enum {C_ALU, C_LW, C_SW, C_BEQ, C_J, C_NOP, C_HALT} cls_t;

  typedef struct {
    logic [5:0] st;
    bit         pce;
    logic [1:0] sel;
    bit         rw;
    bit         mr;
    bit         mw;
    bit         rdy;
    bit         start;
    bit         set_err;
  } rec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_sequencer_if #(.COUNT_W(COUNT_W)) bus();

  fetch_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .COUNT_W(COUNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  rec_t             q[$];
  logic [5:0]       cur_op;
  logic             cur_az;
  bit               do_rst;
  logic [COUNT_W-1:0] m_instr;
  logic [COUNT_W-1:0] m_cycle;
  logic               m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic cls_t classify(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001000: return C_ALU;
      6'b100011:            return C_LW;
      6'b101011:            return C_SW;
      6'b000100:            return C_BEQ;
      6'b000010:            return C_J;
      6'b111111:            return C_HALT;
      default:              return C_NOP;
    endcase
  endfunction

  function automatic rec_t mk(input logic [5:0] st, input bit pce, input logic [1:0] sel,
                              input bit rw, input bit mr, input bit mw, input bit rdy,
                              input bit start, input bit se);
    rec_t r;
    r.st = st; r.pce = pce; r.sel = sel; r.rw = rw; r.mr = mr; r.mw = mw;
    r.rdy = rdy; r.start = start; r.set_err = se;
    return r;
  endfunction

  // Expand one instruction into its expected cycles; w >= MEM_TIMEOUT means memory never answers.
  function automatic bit queue_instr(input logic [5:0] op, input logic az, input int w);
    cls_t c = classify(op);
    bit   lw = (c == C_LW);
    cur_op = op;
    cur_az = az;
    q.push_back(mk(ST_F, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(ST_D, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    case (c)
      C_HALT: begin
        q.push_back(mk(ST_H, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        return 1'b1;
      end
      C_ALU: begin
        q.push_back(mk(ST_E, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(ST_WB, 1, 2'b00, 1, 0, 0, 0, 0, 0));
      end
      C_BEQ: q.push_back(mk(ST_E, 1, az ? 2'b01 : 2'b00, 0, 0, 0, 0, 0, 0));
      C_J:   q.push_back(mk(ST_E, 1, 2'b10, 0, 0, 0, 0, 0, 0));
      C_NOP: q.push_back(mk(ST_E, 1, 2'b00, 0, 0, 0, 0, 0, 0));
      default: begin
        q.push_back(mk(ST_E, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        if (w >= MEM_TIMEOUT) begin
          for (int k = 0; k < MEM_TIMEOUT; k++)
            q.push_back(mk(ST_M, 0, 2'b00, 0, lw, !lw, 0, 0, k == MEM_TIMEOUT - 1));
          q.push_back(mk(ST_H, 0, 2'b00, 0, 0, 0, 0, 0, 0));
          return 1'b1;
        end
        for (int k = 0; k < w; k++)
          q.push_back(mk(ST_M, 0, 2'b00, 0, lw, !lw, 0, 0, 0));
        q.push_back(mk(ST_M, !lw, 2'b00, 0, lw, !lw, 1, 0, 0));
        if (lw) q.push_back(mk(ST_WB, 1, 2'b00, 1, 0, 0, 0, 0, 0));
      end
    endcase
    return 1'b0;
  endfunction

  // Inputs irrelevant to the current phase are randomised to prove they are ignored.
  task automatic step(input rec_t r);
    reset         = do_rst;
    bus.start     = (r.st == ST_IDLE) ? r.start : 1'($urandom);
    bus.opcode    = (r.st == ST_D) ? cur_op : 6'($urandom);
    bus.alu_zero  = (r.st == ST_E) ? cur_az : 1'($urandom);
    bus.mem_ready = (r.st == ST_M) ? r.rdy : 1'($urandom);
    #1;
    check("outs", 64'({bus.state, bus.PC_enable, bus.pc_sel, bus.reg_write, bus.mem_read, bus.mem_write}),
                  64'({r.st, r.pce, r.sel, r.rw, r.mr, r.mw}));
    check("instr_count", 64'(bus.instr_count), 64'(m_instr));
    check("cycle_count", 64'(bus.cycle_count), 64'(m_cycle));
    check("error", 64'(bus.error), 64'(m_err));
    if (do_rst) begin
      m_instr = '0; m_cycle = '0; m_err = 1'b0; do_rst = 1'b0;
    end else begin
      if (r.pce) m_instr = m_instr + 1'b1;
      if (r.st != ST_IDLE && r.st != ST_H) m_cycle = m_cycle + 1'b1;
      if (r.set_err) m_err = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_q();
    while (q.size() > 0) step(q.pop_front());
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    m_instr = '0; m_cycle = '0; m_err = 1'b0;
  endtask

  task automatic begin_prog(input int idle_cycles);
    for (int k = 0; k < idle_cycles; k++) q.push_back(mk(ST_IDLE, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(ST_IDLE, 0, 2'b00, 0, 0, 0, 0, 1, 0));
    run_q();
  endtask

  task automatic run_instr(input logic [5:0] op, input logic az, input int w, output bit halted);
    halted = queue_instr(op, az, w);
    run_q();
  endtask

  task automatic hold_halt(input int n);
    for (int k = 0; k < n; k++) step(mk(ST_H, 0, 2'b00, 0, 0, 0, 0, 0, 0));
  endtask

  function automatic logic [5:0] rand_nop();
    logic [5:0] op;
    do op = 6'($urandom); while (classify(op) != C_NOP);
    return op;
  endfunction

  initial begin
    bit h;
    bus.start = 1'b0; bus.opcode = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
    do_rst = 1'b0;
    m_instr = '0; m_cycle = '0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed: mixed program exercising every class and the MEM wait boundary
    do_reset();
    begin_prog(2);
    run_instr(6'b000000, 1'b0, 0, h);
    run_instr(6'b100011, 1'b0, 3, h);
    run_instr(6'b000100, 1'b1, 0, h);
    run_instr(6'b000100, 1'b0, 0, h);
    run_instr(6'b000010, 1'b1, 0, h);
    run_instr(6'b101011, 1'b0, 0, h);
    run_instr(6'b001000, 1'b0, 0, h);
    run_instr(rand_nop(), 1'b1, 0, h);
    run_instr(6'b111111, 1'b0, 0, h);
    hold_halt(3);

    // Directed: sw that never completes
    do_reset();
    begin_prog(0);
    run_instr(6'b101011, 1'b0, MEM_TIMEOUT, h);
    hold_halt(4);

    // Directed: halt as the first instruction
    do_reset();
    begin_prog(1);
    run_instr(6'b111111, 1'b0, 0, h);
    hold_halt(3);

    // Directed: reset during the second MEM cycle of a lw, then restart
    do_reset();
    begin_prog(0);
    void'(queue_instr(6'b100011, 1'b0, 3));
    for (int k = 0; k < 4; k++) step(q.pop_front());
    do_rst = 1'b1;
    step(q.pop_front());
    q.delete();
    begin_prog(1);
    run_instr(6'b000000, 1'b0, 0, h);
    run_instr(6'b111111, 1'b0, 0, h);
    hold_halt(2);

    // Random programs
    for (int p = 0; p < 25; p++) begin
      do_reset();
      begin_prog($urandom_range(0, 2));
      h = 1'b0;
      for (int i = 0; i < 12 && !h; i++) begin
        logic [5:0] op;
        int w;
        case ($urandom_range(0, 7))
          0: op = 6'b000000;
          1: op = 6'b001000;
          2: op = 6'b100011;
          3: op = 6'b101011;
          4: op = 6'b000100;
          5: op = 6'b000010;
          6: op = rand_nop();
          default: op = ($urandom_range(0, 3) == 0) ? 6'b111111 : 6'b000000;
        endcase
        w = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT : $urandom_range(0, MEM_TIMEOUT - 1);
        run_instr(op, 1'($urandom), w, h);
      end
      if (!h) run_instr(6'b111111, 1'b0, 0, h);
      hold_halt(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
